// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder slice.
package sccb_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ID_BYTE,
      ID_ACK,
      SUB_BYTE,
      SUB_ACK,
      DATA_BYTE,
      DATA_ACK,
      RD_BYTE,
      RD_ACK,
      IGNORE
   } state_t;

   localparam logic        SCCB_RW_WRITE = 1'b0;
   localparam logic        SCCB_RW_READ  = 1'b1;
   localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/sccb_line_sync.sv
// scl/sda synchronizers with edge and START/STOP detection on the synchronized lines.
module sccb_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_sr;
   logic [SYNC_STAGES-1:0] sda_sr;
   logic                   scl_s;
   logic                   scl_d;
   logic                   sda_d;

   // Reset to the idle-bus level so leaving reset does not look like an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sr <= '1;
         sda_sr <= '1;
         scl_d  <= 1'b1;
         sda_d  <= 1'b1;
      end else begin
         scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl};
         sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
         scl_d  <= scl_s;
         sda_d  <= sda_s;
      end
   end

   assign scl_s     = scl_sr[SYNC_STAGES-1];
   assign sda_s     = sda_sr[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target emulating the OV7670 register interface: 256x8 register file,
// 3-phase writes, 2-phase write + 2-phase read.
module sccb_responder
   import sccb_pkg::*;
#(
   parameter logic [6:0]  DEVICE_ID   = 7'h21,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data
);

   localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE);

   state_t     state, state_n;
   logic [3:0] cnt;
   logic [7:0] rx, tx, ptr;
   logic [7:0] mem [256];
   logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
   logic       oe_n, cnt_clr, bit_in, ptr_load, ptr_inc, tx_load, tx_shift, do_write, byte_done;

   sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset     (reset),
      .scl       (scl),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sda_oe    <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         cnt       <= '0;
         rx        <= '0;
         tx        <= '0;
         ptr       <= '0;
         for (int unsigned i = 0; i < 256; i++) mem[i] <= '0;
      end else begin
         state     <= state_n;
         sda_oe    <= oe_n;
         wr_strobe <= do_write;
         if (cnt_clr)     cnt <= '0;
         else if (bit_in) cnt <= cnt + 4'd1;
         if (bit_in)      rx  <= {rx[6:0], sda_s};
         if (ptr_load)    ptr <= rx;
         else if (ptr_inc) ptr <= ptr + 8'd1;
         if (tx_load)       tx <= mem[ptr];
         else if (tx_shift) tx <= {tx[6:0], 1'b0};
         if (do_write) begin
            mem[ptr] <= rx;
            wr_addr  <= ptr;
            wr_data  <= rx;
         end
      end
   end

   always_comb begin
      state_n   = state;
      oe_n      = sda_oe;
      cnt_clr   = 1'b0;
      bit_in    = 1'b0;
      ptr_load  = 1'b0;
      ptr_inc   = 1'b0;
      tx_load   = 1'b0;
      tx_shift  = 1'b0;
      do_write  = 1'b0;
      byte_done = scl_fall && (cnt == LAST_BIT);
      if (start_det) begin
         state_n = ID_BYTE;
         oe_n    = 1'b0;
         cnt_clr = 1'b1;
      end else if (stop_det) begin
         state_n = IDLE;
         oe_n    = 1'b0;
      end else begin
         case (state)
            ID_BYTE, SUB_BYTE, DATA_BYTE, RD_BYTE: bit_in = scl_rise && (cnt < LAST_BIT);
            default: ;
         endcase
         case (state)
            ID_BYTE:
               if (byte_done) begin
                  if (rx[7:1] == DEVICE_ID) begin
                     oe_n    = 1'b1;
                     state_n = ID_ACK;
                  end else begin
                     state_n = IGNORE;
                  end
               end
            // rx is frozen during ACK slots, so rx[0] still holds the R/W bit here.
            ID_ACK:
               if (scl_fall) begin
                  oe_n    = 1'b0;
                  cnt_clr = 1'b1;
                  if (rx[0] == SCCB_RW_READ) begin
                     state_n = RD_BYTE;
                     tx_load = 1'b1;
                     oe_n    = ~mem[ptr][7];
                  end else begin
                     state_n = SUB_BYTE;
                  end
               end
            SUB_BYTE:
               if (byte_done) begin
                  ptr_load = 1'b1;
                  oe_n     = 1'b1;
                  state_n  = SUB_ACK;
               end
            DATA_BYTE:
               if (byte_done) begin
                  do_write = 1'b1;
                  ptr_inc  = 1'b1;
                  oe_n     = 1'b1;
                  state_n  = DATA_ACK;
               end
            SUB_ACK, DATA_ACK:
               if (scl_fall) begin
                  oe_n    = 1'b0;
                  cnt_clr = 1'b1;
                  state_n = DATA_BYTE;
               end
            // A fall with cnt==0 only occurs after a master ACK: fetch the next byte.
            RD_BYTE:
               if (scl_fall) begin
                  if (cnt == 4'd0) begin
                     tx_load = 1'b1;
                     oe_n    = ~mem[ptr][7];
                  end else if (cnt == LAST_BIT) begin
                     oe_n    = 1'b0;
                     ptr_inc = 1'b1;
                     state_n = RD_ACK;
                  end else begin
                     tx_shift = 1'b1;
                     oe_n     = ~tx[6];
                  end
               end
            RD_ACK:
               if (scl_rise) begin
                  cnt_clr = 1'b1;
                  state_n = sda_s ? IGNORE : RD_BYTE;
               end
            default: ;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign dbg_data = mem[dbg_addr];

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- SCCB/I2C target (slave) that emulates the register-programming side of an OV7670 camera.
- Receives 3-phase writes and 2-phase write + 2-phase read transactions from the on-chip SCCB initiator.
- Holds a 256x8 register file.
- Used as the camera-side model in simulation and as a loopback target on the FPGA, so the camera init sequence can be checked without a sensor.

Parameters:
- DEVICE_ID, 7'h21, 7-bit target address; write ID byte 0x42, read ID byte 0x43.
- SYNC_STAGES, 2, flops in the scl/sda input synchronizers (minimum 2).

Ports:
- clk  input  1  system clock (50 MHz); must be ≥ 8x the scl frequency.
- reset  input  1  asynchronous, active-high.
- scl  input  1  SCCB clock from the initiator.
- sda_in  input  1  SCCB data as seen on the bus.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- wr_strobe  output  1  one-clk pulse when a data byte is committed.
- wr_addr  output  8  register address of the committed byte.
- wr_data  output  8  committed data byte.
- busy  output  1  high from START until STOP or abort.
- dbg_addr  input  8  debug read address.
- dbg_data  output  8  mem[dbg_addr], combinational.

Behaviour:
- Reset (async): all state cleared, state returns to IDLE, register file cleared to 0x00, and the sub-address pointer is set to 0.
  - sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
- Input conditioning: scl/sda pass through SYNC_STAGES flops; edges are detected one cycle later.
  - Total detection latency is SYNC_STAGES+1 clk.
- START = sda falls while scl high. STOP = sda rises while scl high. Both are detected from the synchronized signals.
- Data bits are sampled on the scl rising edge, MSB first. sda_oe changes only on the detected scl falling edge.
- States: IDLE, ID_BYTE, ID_ACK, SUB_BYTE, SUB_ACK, DATA_BYTE, DATA_ACK, RD_BYTE, RD_ACK, IGNORE.
- IDLE → ID_BYTE on START; busy=1. A 4-bit bit counter is cleared on entry to every *_BYTE state.
- ID_BYTE, after 8 bits:
  - Upper 7 bits == DEVICE_ID → drive ACK: sda_oe=1 from the 8th scl falling edge to the 9th scl falling edge.
  - Then, if R/W=0, go to SUB_BYTE; if R/W=1, go to RD_BYTE.
  - Mismatch → IGNORE; sda_oe stays 0 until STOP or START.
- SUB_BYTE, after 8 bits: pointer ← byte, ACK as above, then DATA_BYTE.
  - A STOP here completes a 2-phase write; the pointer is kept.
- DATA_BYTE, after 8 bits: ACK as above.
  - On the 8th scl falling edge: mem[pointer] ← byte, wr_strobe=1 for exactly 1 clk, wr_addr=pointer, wr_data=byte.
  - pointer ← pointer+1, mod 256 (0xFF wraps to 0x00).
  - Then return to DATA_BYTE for further bytes.
- RD_BYTE: the byte mem[pointer] is latched into a shift register when the ID ACK is released.
  - Each bit is placed on the bus by driving sda_oe=~bit, updated on each scl falling edge.
  - After 8 bits: release sda_oe, pointer ← pointer+1, go to RD_ACK.
- RD_ACK: sample sda on the 9th scl rising edge.
  - 0 (ACK) → RD_BYTE with the next byte.
  - 1 (NAK) → IGNORE, no further driving.
- wr_addr/wr_data hold their last values between strobes.
- Repeated START in any non-IDLE state:
  - Discard any partial byte, release sda_oe immediately, clear the bit counter, go to ID_BYTE.
  - No write is issued for the partial byte.
- STOP in any state: release sda_oe, go to IDLE, busy=0. The pointer is kept.
- START and STOP cannot be detected in the same clk; the scl-high qualifier applies to each.
- An scl edge coincident with a START/STOP detection: START/STOP takes priority.
- Reset mid-transaction: outputs return to their reset values within the same cycle (async), and the register file is cleared.

Decomposition:
- Package sccb_pkg holds:
  - state_t enum (4-bit);
  - constants SCCB_RW_WRITE=1'b0 and SCCB_RW_READ=1'b1;
  - BITS_PER_BYTE=8.
- Sub-module sccb_line_sync: synchronizers plus edge/START/STOP detection.
  - Outputs: scl_rise, scl_fall, start_det, stop_det, sda_s.
- The FSM, shift registers and register file live in sccb_responder.

Test Plan:
- 3-phase write:
  - Stimulus: ID 0x42, sub 0x12, data 0x80, STOP.
  - Required: sda_oe=1 in all three ACK slots; a single wr_strobe with wr_addr=0x12, wr_data=0x80; dbg_data@0x12=0x80; busy=0 within SYNC_STAGES+2 clk after STOP.
- Wrong ID:
  - Stimulus: ID 0x60, 0x12, 0x55.
  - Required: sda_oe=0 throughout; no wr_strobe; mem[0x12] unchanged; pointer unchanged.
- Write then read:
  - Stimulus: preload mem[0x0A]=0x76 by a write; 2-phase write 0x42/0x0A, STOP; then 0x43, 8 clocks, master NAK, STOP.
  - Required: bus bits 0,1,1,1,0,1,1,0 observed; sda_oe=0 after the 8th bit; no drive after NAK.
- Burst write with wrap:
  - Stimulus: ID 0x42, sub 0xFF, data 0x11, 0x22.
  - Required: mem[0xFF]=0x11, mem[0x00]=0x22; two strobes with wr_addr 0xFF then 0x00.
- Repeated START:
  - Stimulus: repeated START after 4 bits of a data byte, then 0x42/0x05/0x33.
  - Required: no strobe for the partial byte; a single strobe with addr 0x05, data 0x33.
- Reset during ACK:
  - Stimulus: assert reset while sda_oe=1 during a DATA ACK.
  - Required: sda_oe=0 and busy=0 within the same cycle; all mem reads 0x00; a following valid write is accepted.
